// File: rtl/clk_div_pkg.sv
// Shared types, constants and helpers for the programmable clock divider.
// Imported by the divider top and its phase/tick counter.
package clk_div_pkg;

    localparam int unsigned MIN_DIV = 2;

    typedef enum logic {
        CFG_IDLE,
        CFG_PEND
    } cfg_state_t;

    // Counter value on whose edge clk_out rises; callers guarantee n >= 2.
    function automatic int unsigned half_m1(input int unsigned n);
        return (n >> 1) - 1;
    endfunction

    function automatic bit default_div_legal(input int unsigned div, input int unsigned w);
        return (div >= MIN_DIV) && (64'(div) < (64'd1 << w));
    endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Divisor reload handshake between a configuring master and the divider.
interface clk_div_prog_if #(
    parameter int CNT_W = 8
) ();

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] div_val;

    modport master (
        output cfg_valid,
        output div_val,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  div_val,
        output cfg_ready
    );

endinterface

// File: rtl/clk_div_prog_wrap_cnt.sv
// Enable-gated up counter that wraps to zero after reaching i_max.
// i_clr forces zero regardless of enable.
module wrap_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_max,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == i_max) ? '0 : r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider producing a divided waveform,
// a clock-enable tick and a wrapping tick count, all in the clk domain.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int TICK_W      = 2,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    clk_div_prog_if.slave       cfg,
    output logic                o_clk_out,
    output logic                o_tick,
    output logic [TICK_W-1:0]   o_tick_cnt,
    output logic                o_cfg_err
);

    localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MIN_DIV_W = CNT_W'(MIN_DIV);

    if (!default_div_legal(DEFAULT_DIV, CNT_W)) begin : g_bad_default
        $error("clk_div_prog: DEFAULT_DIV must satisfy 2 <= DEFAULT_DIV < 2**CNT_W");
    end

    cfg_state_t         r_state;
    cfg_state_t         w_state_nxt;
    logic [CNT_W-1:0]   r_div;
    logic [CNT_W-1:0]   r_pend;
    logic               r_clk_out;
    logic               r_tick;
    logic               r_cfg_err;

    logic [CNT_W-1:0]   w_cnt;
    logic [CNT_W-1:0]   w_last;
    logic [CNT_W-1:0]   w_half;
    logic [TICK_W-1:0]  w_tick_cnt;
    logic               w_wrap;
    logic               w_at_half;
    logic               w_rise;
    logic               w_cfg_ready;
    logic               w_capture;
    logic               w_apply;
    logic               w_apply_idle;

    assign w_last    = r_div - CNT_W'(1);
    assign w_half    = CNT_W'(half_m1(32'(r_div)));
    assign w_wrap    = (w_cnt == w_last);
    assign w_at_half = (w_cnt == w_half);
    assign w_rise    = i_en && w_at_half;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CFG_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A pending divisor waits for a period boundary while running, or lands at once while frozen.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CFG_IDLE: begin
                if (cfg.cfg_valid) begin
                    w_state_nxt = CFG_PEND;
                end
            end
            CFG_PEND: begin
                if (!i_en || w_wrap) begin
                    w_state_nxt = CFG_IDLE;
                end
            end
            default: begin
                w_state_nxt = CFG_IDLE;
            end
        endcase
    end

    always_comb begin
        w_cfg_ready  = 1'b0;
        w_capture    = 1'b0;
        w_apply      = 1'b0;
        w_apply_idle = 1'b0;
        case (r_state)
            CFG_IDLE: begin
                w_cfg_ready = 1'b1;
                w_capture   = cfg.cfg_valid;
            end
            CFG_PEND: begin
                w_apply      = !i_en || w_wrap;
                w_apply_idle = !i_en;
            end
            default: begin
                w_cfg_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div     <= DEF_DIV_W;
            r_pend    <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            if (w_capture) begin
                r_pend <= (cfg.div_val < MIN_DIV_W) ? MIN_DIV_W : cfg.div_val;
                if (cfg.div_val < MIN_DIV_W) begin
                    r_cfg_err <= 1'b1;
                end
            end
            if (w_apply) begin
                r_div <= r_pend;
            end
        end
    end

    // Applying while frozen restarts the phase, so the waveform must drop with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (w_apply_idle) begin
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (i_en) begin
            r_tick <= w_rise;
            if (w_wrap) begin
                r_clk_out <= 1'b0;
            end else if (w_at_half) begin
                r_clk_out <= 1'b1;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    wrap_cnt #(
        .W (CNT_W)
    ) u_phase (
        .clk   (clk),
        .rst   (rst),
        .i_en  (i_en),
        .i_clr (w_apply_idle),
        .i_max (w_last),
        .o_cnt (w_cnt)
    );

    wrap_cnt #(
        .W (TICK_W)
    ) u_ticks (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_rise),
        .i_clr (1'b0),
        .i_max ('1),
        .o_cnt (w_tick_cnt)
    );

    assign cfg.cfg_ready = w_cfg_ready;
    assign o_clk_out     = r_clk_out;
    assign o_tick        = r_tick;
    assign o_tick_cnt    = w_tick_cnt;
    assign o_cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog with hand-computed waveforms
// covering reset, reconfiguration at idle and mid-run, freeze/resume, bad divisors and reset.
module tb_clk_div_prog;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clkOut;
    logic       tick;
    logic [1:0] tickCnt;
    logic       cfgErr;

    int checks   = 0;
    int failures = 0;

    clk_div_prog_if #(.CNT_W(8)) cfgIf ();

    clk_div_prog #(
        .CNT_W       (8),
        .TICK_W      (2),
        .DEFAULT_DIV (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (en),
        .cfg        (cfgIf),
        .o_clk_out  (clkOut),
        .o_tick     (tick),
        .o_tick_cnt (tickCnt),
        .o_cfg_err  (cfgErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected values after each active edge, in order.
    int n4Clk[16]  = '{0,1,1,0, 0,1,1,0, 0,1,1,0, 0,1,1,0};
    int n4Tick[16] = '{0,1,0,0, 0,1,0,0, 0,1,0,0, 0,1,0,0};
    int n4Tc[16]   = '{0,1,1,1, 1,2,2,2, 2,3,3,3, 3,0,0,0};
    int n5Clk[10]  = '{0,1,1,1,0, 0,1,1,1,0};
    int n5Tick[10] = '{0,1,0,0,0, 0,1,0,0,0};
    int n7Clk[7]   = '{0,0,1,1,1,1,0};
    int n7Tick[7]  = '{0,0,1,0,0,0,0};
    int n2Clk[6]   = '{1,0,1,0,1,0};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic enV, input logic validV, input logic [7:0] divV);
        en                = enV;
        cfgIf.cfg_valid   = validV;
        cfgIf.div_val     = divV;
    endtask

    task automatic loadDivIdle(input logic [7:0] divV);
        applyStimulus(1'b0, 1'b1, divV);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 8'd0);
        stepCycles(1);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'd0);
        stepCycles(2);
        checkOutput("rst clk_out", 32'(clkOut), 0);
        checkOutput("rst tick", 32'(tick), 0);
        checkOutput("rst tick_cnt", 32'(tickCnt), 0);
        checkOutput("rst cfg_ready", 32'(cfgIf.cfg_ready), 1);
        checkOutput("rst cfg_err", 32'(cfgErr), 0);
        rst = 1'b0;

        $display("[TB] default divisor 4 free running");
        applyStimulus(1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 16; k++) begin
            stepCycles(1);
            checkOutput($sformatf("n4 clk_out e%0d", k + 1), 32'(clkOut), n4Clk[k]);
            checkOutput($sformatf("n4 tick e%0d", k + 1), 32'(tick), n4Tick[k]);
            checkOutput($sformatf("n4 tick_cnt e%0d", k + 1), 32'(tickCnt), n4Tc[k]);
        end

        $display("[TB] load divisor 5 while frozen");
        applyStimulus(1'b0, 1'b1, 8'd5);
        stepCycles(1);
        checkOutput("cfg5 ready after capture", 32'(cfgIf.cfg_ready), 0);
        applyStimulus(1'b0, 1'b0, 8'd0);
        stepCycles(1);
        checkOutput("cfg5 ready after apply", 32'(cfgIf.cfg_ready), 1);
        checkOutput("cfg5 clk_out after apply", 32'(clkOut), 0);
        applyStimulus(1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 10; k++) begin
            stepCycles(1);
            checkOutput($sformatf("n5 clk_out e%0d", k + 1), 32'(clkOut), n5Clk[k]);
            checkOutput($sformatf("n5 tick e%0d", k + 1), 32'(tick), n5Tick[k]);
        end
        checkOutput("n5 tick_cnt", 32'(tickCnt), 2);

        $display("[TB] reload 7 mid-period under divisor 4");
        loadDivIdle(8'd4);
        applyStimulus(1'b1, 1'b0, 8'd0);
        stepCycles(1);
        applyStimulus(1'b1, 1'b1, 8'd7);
        stepCycles(1);
        checkOutput("cfg7 ready after capture", 32'(cfgIf.cfg_ready), 0);
        checkOutput("cfg7 clk_out old period", 32'(clkOut), 1);
        checkOutput("cfg7 tick old period", 32'(tick), 1);
        checkOutput("cfg7 tick_cnt old period", 32'(tickCnt), 3);
        applyStimulus(1'b1, 1'b1, 8'd3);
        stepCycles(1);
        checkOutput("cfg7 ready while pending", 32'(cfgIf.cfg_ready), 0);
        checkOutput("cfg7 clk_out still old", 32'(clkOut), 1);
        stepCycles(1);
        checkOutput("cfg7 ready after wrap", 32'(cfgIf.cfg_ready), 1);
        checkOutput("cfg7 clk_out at wrap", 32'(clkOut), 0);
        applyStimulus(1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 7; k++) begin
            stepCycles(1);
            checkOutput($sformatf("n7 clk_out e%0d", k + 1), 32'(clkOut), n7Clk[k]);
            checkOutput($sformatf("n7 tick e%0d", k + 1), 32'(tick), n7Tick[k]);
        end
        checkOutput("n7 tick_cnt", 32'(tickCnt), 0);

        $display("[TB] freeze with clk_out high under divisor 4");
        loadDivIdle(8'd4);
        applyStimulus(1'b1, 1'b0, 8'd0);
        stepCycles(2);
        checkOutput("freeze pre clk_out", 32'(clkOut), 1);
        checkOutput("freeze pre tick", 32'(tick), 1);
        applyStimulus(1'b0, 1'b0, 8'd0);
        for (int k = 0; k < 10; k++) begin
            stepCycles(1);
            checkOutput($sformatf("frozen clk_out e%0d", k + 1), 32'(clkOut), 1);
            checkOutput($sformatf("frozen tick e%0d", k + 1), 32'(tick), 0);
        end
        checkOutput("frozen tick_cnt", 32'(tickCnt), 1);
        applyStimulus(1'b1, 1'b0, 8'd0);
        stepCycles(1);
        checkOutput("resume clk_out r1", 32'(clkOut), 1);
        stepCycles(1);
        checkOutput("resume clk_out r2", 32'(clkOut), 0);
        stepCycles(1);
        checkOutput("resume clk_out r3", 32'(clkOut), 0);
        checkOutput("resume tick r3", 32'(tick), 0);
        stepCycles(1);
        checkOutput("resume clk_out r4", 32'(clkOut), 1);
        checkOutput("resume tick r4", 32'(tick), 1);
        checkOutput("resume tick_cnt r4", 32'(tickCnt), 2);

        $display("[TB] illegal divisor 1");
        applyStimulus(1'b0, 1'b1, 8'd1);
        stepCycles(1);
        checkOutput("cfg1 cfg_err set", 32'(cfgErr), 1);
        checkOutput("cfg1 ready after capture", 32'(cfgIf.cfg_ready), 0);
        applyStimulus(1'b0, 1'b0, 8'd0);
        stepCycles(1);
        checkOutput("cfg1 clk_out after apply", 32'(clkOut), 0);
        checkOutput("cfg1 ready after apply", 32'(cfgIf.cfg_ready), 1);
        applyStimulus(1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 6; k++) begin
            stepCycles(1);
            checkOutput($sformatf("n2 clk_out e%0d", k + 1), 32'(clkOut), n2Clk[k]);
            checkOutput($sformatf("n2 tick e%0d", k + 1), 32'(tick), n2Clk[k]);
        end
        checkOutput("n2 tick_cnt", 32'(tickCnt), 1);
        checkOutput("n2 cfg_err sticky", 32'(cfgErr), 1);

        $display("[TB] reset with pending divisor 9");
        applyStimulus(1'b1, 1'b1, 8'd9);
        stepCycles(1);
        checkOutput("cfg9 ready after capture", 32'(cfgIf.cfg_ready), 0);
        applyStimulus(1'b1, 1'b0, 8'd0);
        rst = 1'b1;
        stepCycles(1);
        rst = 1'b0;
        checkOutput("midrst clk_out", 32'(clkOut), 0);
        checkOutput("midrst tick", 32'(tick), 0);
        checkOutput("midrst tick_cnt", 32'(tickCnt), 0);
        checkOutput("midrst cfg_ready", 32'(cfgIf.cfg_ready), 1);
        checkOutput("midrst cfg_err", 32'(cfgErr), 0);
        for (int k = 0; k < 8; k++) begin
            stepCycles(1);
            checkOutput($sformatf("post-rst clk_out e%0d", k + 1), 32'(clkOut), n4Clk[k]);
        end
        checkOutput("post-rst tick_cnt", 32'(tickCnt), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
